// File: rtl/sc_input_conditioner_if.sv
// Button/ready bundle between the raw panel inputs, the input conditioner
// and the game state machine.
interface sc_input_conditioner_if;
    logic SC_INPUT_CONDITIONER_startButton_InLow;
    logic SC_INPUT_CONDITIONER_jug1Button_InLow;
    logic SC_INPUT_CONDITIONER_jug2Button_InLow;
    logic SC_INPUT_CONDITIONER_readyClear_InLow;
    logic SC_INPUT_CONDITIONER_startButton_OutLow;
    logic SC_INPUT_CONDITIONER_jug1Ready_OutLow;
    logic SC_INPUT_CONDITIONER_jug2Ready_OutLow;

    modport master (
        output SC_INPUT_CONDITIONER_startButton_InLow,
        output SC_INPUT_CONDITIONER_jug1Button_InLow,
        output SC_INPUT_CONDITIONER_jug2Button_InLow,
        output SC_INPUT_CONDITIONER_readyClear_InLow,
        input  SC_INPUT_CONDITIONER_startButton_OutLow,
        input  SC_INPUT_CONDITIONER_jug1Ready_OutLow,
        input  SC_INPUT_CONDITIONER_jug2Ready_OutLow
    );

    modport slave (
        input  SC_INPUT_CONDITIONER_startButton_InLow,
        input  SC_INPUT_CONDITIONER_jug1Button_InLow,
        input  SC_INPUT_CONDITIONER_jug2Button_InLow,
        input  SC_INPUT_CONDITIONER_readyClear_InLow,
        output SC_INPUT_CONDITIONER_startButton_OutLow,
        output SC_INPUT_CONDITIONER_jug1Ready_OutLow,
        output SC_INPUT_CONDITIONER_jug2Ready_OutLow
    );
endinterface

// File: rtl/sc_input_conditioner.sv
// Synchronizes and debounces the start and player buttons; start becomes a
// one-cycle press pulse, player buttons become latched ready flags.
module sc_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DEBOUNCE_WIDTH  = 20
) (
    input  logic                   SC_INPUT_CONDITIONER_CLOCK_50,
    input  logic                   SC_INPUT_CONDITIONER_RESET_InHigh,
    sc_input_conditioner_if.slave  bus
);

    typedef enum logic {
        WAIT  = 1'b0,
        READY = 1'b1
    } rdy_state_e;

    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_MAX =
        DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic clk;
    logic rst;
    logic clear_n;
    logic [2:0] raw;

    assign clk     = SC_INPUT_CONDITIONER_CLOCK_50;
    assign rst     = SC_INPUT_CONDITIONER_RESET_InHigh;
    assign clear_n = bus.SC_INPUT_CONDITIONER_readyClear_InLow;

    // Channel order: 0 = start, 1 = jug1, 2 = jug2
    assign raw = {bus.SC_INPUT_CONDITIONER_jug2Button_InLow,
                  bus.SC_INPUT_CONDITIONER_jug1Button_InLow,
                  bus.SC_INPUT_CONDITIONER_startButton_InLow};

    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] stable_q, stable_d;
    logic [2:0] stable_prev_q, stable_prev_d;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q [3];
    logic [DEBOUNCE_WIDTH-1:0] cnt_d [3];
    logic [2:0] press;

    logic start_out_q, start_out_d;
    rdy_state_e state_q [2];
    rdy_state_e state_d [2];
    logic [1:0] ready_out_q, ready_out_d;

    always_comb begin
        sync1_d       = raw;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Falling edge of the accepted level; releases generate nothing
    assign press = ~stable_q & stable_prev_q;

    assign start_out_d = ~press[0];

    always_comb begin
        for (int j = 0; j < 2; j++) begin
            state_d[j] = state_q[j];
            unique case (state_q[j])
                WAIT: begin
                    // A coincident clear beats the press
                    if (press[j+1] && clear_n) begin
                        state_d[j] = READY;
                    end
                end
                READY: begin
                    if (!clear_n) begin
                        state_d[j] = WAIT;
                    end
                end
            endcase
            ready_out_d[j] = (state_d[j] != READY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            stable_q      <= '1;
            stable_prev_q <= '1;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            start_out_q <= 1'b1;
            for (int j = 0; j < 2; j++) begin
                state_q[j] <= WAIT;
            end
            ready_out_q <= '1;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            start_out_q <= start_out_d;
            for (int j = 0; j < 2; j++) begin
                state_q[j] <= state_d[j];
            end
            ready_out_q <= ready_out_d;
        end
    end

    assign bus.SC_INPUT_CONDITIONER_startButton_OutLow = start_out_q;
    assign bus.SC_INPUT_CONDITIONER_jug1Ready_OutLow   = ready_out_q[0];
    assign bus.SC_INPUT_CONDITIONER_jug2Ready_OutLow   = ready_out_q[1];

endmodule

// File: tb/tb_sc_input_conditioner.sv
// Bench for sc_input_conditioner: directed scenarios plus random button
// activity, all checked every cycle against a sample-window reference model.
module tb_sc_input_conditioner;

    localparam int N = 4;

    logic clk;
    logic rst;
    logic st, j1, j2, clr;

    sc_input_conditioner_if bus ();

    assign bus.SC_INPUT_CONDITIONER_startButton_InLow = st;
    assign bus.SC_INPUT_CONDITIONER_jug1Button_InLow  = j1;
    assign bus.SC_INPUT_CONDITIONER_jug2Button_InLow  = j2;
    assign bus.SC_INPUT_CONDITIONER_readyClear_InLow  = clr;

    sc_input_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .DEBOUNCE_WIDTH (4)
    ) dut (
        .SC_INPUT_CONDITIONER_CLOCK_50    (clk),
        .SC_INPUT_CONDITIONER_RESET_InHigh(rst),
        .bus                              (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: level seen by the debouncer is the raw sample from
    // two edges earlier; a new level is accepted once the last N seen
    // samples all disagree with the accepted level.
    logic         dly0 [3];
    logic         dly1 [3];
    logic [N-1:0] hist [3];
    logic         m_stable [3];
    logic         m_prev [3];
    logic         m_start;
    logic         m_rdy [2];

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            dly0[c]     = 1'b1;
            dly1[c]     = 1'b1;
            hist[c]     = '1;
            m_stable[c] = 1'b1;
            m_prev[c]   = 1'b1;
        end
        m_start  = 1'b1;
        m_rdy[0] = 1'b0;
        m_rdy[1] = 1'b0;
    endtask

    task automatic model_edge();
        logic raw [3];
        logic pr [3];
        logic acc [3];
        logic seen;
        raw[0] = st;
        raw[1] = j1;
        raw[2] = j2;
        for (int c = 0; c < 3; c++) begin
            seen    = dly1[c];
            dly1[c] = dly0[c];
            dly0[c] = raw[c];
            hist[c] = {hist[c][N-2:0], seen};
            acc[c]  = (hist[c] == {N{~m_stable[c]}});
            pr[c]   = !m_stable[c] && m_prev[c];
        end
        m_start = !pr[0];
        for (int p = 0; p < 2; p++) begin
            if (!clr) m_rdy[p] = 1'b0;
            else if (pr[p+1]) m_rdy[p] = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            m_prev[c] = m_stable[c];
            if (acc[c]) m_stable[c] = ~m_stable[c];
        end
    endtask

    int eidx;
    int zfirst [3];
    int zcount [3];

    task automatic clr_stats(input int first);
        eidx = first;
        for (int c = 0; c < 3; c++) begin
            zfirst[c] = -1;
            zcount[c] = 0;
        end
    endtask

    task automatic tick();
        logic o [3];
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        o[0] = bus.SC_INPUT_CONDITIONER_startButton_OutLow;
        o[1] = bus.SC_INPUT_CONDITIONER_jug1Ready_OutLow;
        o[2] = bus.SC_INPUT_CONDITIONER_jug2Ready_OutLow;
        chk("start_out", o[0], m_start);
        chk("jug1_ready", o[1], !m_rdy[0]);
        chk("jug2_ready", o[2], !m_rdy[1]);
        for (int c = 0; c < 3; c++) begin
            if (!o[c]) begin
                if (zfirst[c] < 0) zfirst[c] = eidx;
                zcount[c]++;
            end
        end
        eidx++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        st  = 1'b1;
        j1  = 1'b1;
        j2  = 1'b1;
        clr = 1'b1;
        model_reset();
        clr_stats(0);

        // Reset with everything released
        ticks(3);
        chk("rst_start", bus.SC_INPUT_CONDITIONER_startButton_OutLow, 1);
        chk("rst_jug1", bus.SC_INPUT_CONDITIONER_jug1Ready_OutLow, 1);
        chk("rst_jug2", bus.SC_INPUT_CONDITIONER_jug2Ready_OutLow, 1);

        // Start held across reset release
        st = 1'b0;
        tick();
        rst = 1'b0;
        clr_stats(1);
        ticks(20);
        chk("held_rst_edge", zfirst[0], 7);
        chk("held_rst_cnt", zcount[0], 1);
        st = 1'b1;
        ticks(10);

        // Clean press, long hold, then release and re-press
        clr_stats(0);
        st = 1'b0;
        ticks(100);
        chk("clean_edge", zfirst[0], 6);
        chk("clean_cnt", zcount[0], 1);
        st = 1'b1;
        ticks(10);
        clr_stats(0);
        st = 1'b0;
        ticks(20);
        chk("repress_edge", zfirst[0], 6);
        chk("repress_cnt", zcount[0], 1);
        st = 1'b1;
        ticks(10);

        // Bounce shorter than the debounce window
        clr_stats(0);
        for (int i = 0; i < 50; i++) begin
            st = ((i % 5) < 3) ? 1'b0 : 1'b1;
            tick();
        end
        st = 1'b1;
        ticks(8);
        chk("bounce_cnt", zcount[0], 0);

        // Ready latch and clear
        clr_stats(0);
        j1 = 1'b0;
        ticks(10);
        j1 = 1'b1;
        ticks(20);
        chk("latch_edge", zfirst[1], 6);
        chk("latch_held", bus.SC_INPUT_CONDITIONER_jug1Ready_OutLow, 0);
        clr = 1'b0;
        tick();
        clr = 1'b1;
        chk("latch_clr", bus.SC_INPUT_CONDITIONER_jug1Ready_OutLow, 1);
        chk("latch_jug2", zcount[2], 0);
        ticks(5);

        // Clear coinciding with jug2 press event
        clr_stats(0);
        j2 = 1'b0;
        ticks(6);
        clr = 1'b0;
        tick();
        clr = 1'b1;
        chk("coll_now", bus.SC_INPUT_CONDITIONER_jug2Ready_OutLow, 1);
        ticks(10);
        chk("coll_cnt", zcount[2], 0);
        j2 = 1'b1;
        ticks(10);

        // Simultaneous player presses
        clr_stats(0);
        j1 = 1'b0;
        j2 = 1'b0;
        ticks(12);
        chk("simul_j1", zfirst[1], 6);
        chk("simul_j2", zfirst[2], 6);
        j1 = 1'b1;
        j2 = 1'b1;
        ticks(10);
        clr = 1'b0;
        tick();
        clr = 1'b1;

        // Reset in the middle of a debounce count
        clr_stats(0);
        j1 = 1'b0;
        ticks(4);
        rst = 1'b1;
        tick();
        chk("midrst_rdy", bus.SC_INPUT_CONDITIONER_jug1Ready_OutLow, 1);
        rst = 1'b0;
        clr_stats(1);
        ticks(12);
        chk("midrst_edge", zfirst[1], 7);
        j1 = 1'b1;
        ticks(10);

        // Random activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) st = ~st;
            if ($urandom_range(5) == 0) j1 = ~j1;
            if ($urandom_range(5) == 0) j2 = ~j2;
            clr = ($urandom_range(19) != 0);
            rst = ($urandom_range(199) == 0);
            tick();
        end
        rst = 1'b0;
        clr = 1'b1;
        ticks(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
